// File: rtl/display_scan_mux.sv
// Four-digit time-multiplexed 7-segment scanner with frame-aligned loads.
// Optional LEADING_ZERO_BLANK_EN macro turns off leading-zero digits.
module display_scan_mux #(
  parameter int PRESCALE = 100000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] x,
  input  logic        ld,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        pending
);

  localparam logic [23:0] PMAX = 24'(PRESCALE - 1);

  logic [23:0] pcnt, pcnt_n;
  logic [1:0]  idx, idx_n;
  logic [15:0] disp, disp_n;
  logic [15:0] shadow, shadow_n;
  logic        pend_n;
  logic [3:0]  digit_n;
  logic [3:0]  an_n;
  logic        tick;
  logic        boundary;
  logic        blank;

  // Prescaler and digit index advance.
  always_comb begin
    tick     = (pcnt == PMAX);
    boundary = tick && (idx == 2'd3);
    pcnt_n   = tick ? 24'd0 : pcnt + 24'd1;
    idx_n    = tick ? idx + 2'd1 : idx;
  end

  // Load buffering: loads land in shadow and move to disp only at a
  // frame boundary, so a number is never split across two frames.
  always_comb begin
    disp_n   = disp;
    shadow_n = shadow;
    pend_n   = pending;
    if (ld && boundary) begin
      disp_n = x;
      pend_n = 1'b0;
    end else if (ld) begin
      shadow_n = x;
      pend_n   = 1'b1;
    end else if (boundary && pending) begin
      disp_n = shadow;
      pend_n = 1'b0;
    end
  end

  // Nibble select and blanking for the digit shown after this edge.
  always_comb begin
    digit_n = disp_n[3:0];
    blank   = 1'b0;
    unique case (idx_n)
      2'd0: digit_n = disp_n[3:0];
      2'd1: begin
        digit_n = disp_n[7:4];
        blank   = (disp_n[15:4] == 12'd0);
      end
      2'd2: begin
        digit_n = disp_n[11:8];
        blank   = (disp_n[15:8] == 8'd0);
      end
      2'd3: begin
        digit_n = disp_n[15:12];
        blank   = (disp_n[15:12] == 4'd0);
      end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    an_n = blank ? 4'b1111 : ~(4'b0001 << idx_n);
`else
    an_n = ~(4'b0001 << idx_n);
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pcnt    <= 24'd0;
      idx     <= 2'd0;
      disp    <= 16'd0;
      shadow  <= 16'd0;
      pending <= 1'b0;
      digit   <= 4'h0;
      an      <= 4'b1110;
    end else begin
      pcnt    <= pcnt_n;
      idx     <= idx_n;
      disp    <= disp_n;
      shadow  <= shadow_n;
      pending <= pend_n;
      digit   <= digit_n;
      an      <= an_n;
    end
  end

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Time-multiplexing scanner for a 4-digit common-anode 7-segment display. It sits directly upstream of the hex-to-segment decoder and drives that decoder's 4-bit input with one hex nibble at a time. It also generates the active-low anode strobes for the digit currently shown. A load handshake buffers new 16-bit values and swaps them in only at a frame boundary, so a displayed number is never torn across digits.

## Interface
- PRESCALE, default 100000: clk cycles each digit is held; legal range 2..2^24-1.
- clk  in  1  system clock; all state updates on its rising edge.
- clr  in  1  asynchronous, active-high reset.
- x  in  16  value to display; x[3:0] is the rightmost digit (digit 0).
- ld  in  1  load strobe; samples x on the rising edge where ld=1.
- digit  out  4  hex nibble for the currently selected digit; feeds the segment decoder.
- an  out  4  anode enables, active-low, one-hot-zero; an[i]=0 lights digit i.
- pending  out  1  high while a loaded value waits for the next frame boundary.

## Operation
- State:
  - pcnt: prescaler, 24 bits, counts 0..PRESCALE-1.
  - idx: digit index, 2 bits.
  - disp: displayed value, 16 bits.
  - shadow: buffered value, 16 bits.
  - pending: 1 bit.
- Tick: a tick occurs when pcnt==PRESCALE-1. On a tick, pcnt becomes 0 and idx becomes idx+1 mod 4 (3 wraps to 0). Otherwise pcnt increments.
- Frame boundary: a tick with idx==3.
- ld handling, evaluated each edge in priority order:
  - ld=1 on a frame-boundary edge: disp<=x and pending<=0. The transfer is immediate; the old shadow is discarded.
  - ld=1 on any other edge: shadow<=x and pending<=1. Repeated loads before a boundary overwrite shadow (last write wins).
  - ld=0 on a frame boundary with pending=1: disp<=shadow and pending<=0.
- Outputs are registered. On every edge they reflect the next-state idx and disp:
  - digit <= disp_next[4*idx_next +: 4].
  - an <= ~(4'b0001 << idx_next), unless the digit is blanked (see Configuration).
- Scan order: digit 0, 1, 2, 3, then repeat; each digit is held exactly PRESCALE cycles.

## Timing
- Reset values (asynchronous, while clr=1): pcnt=0, idx=0, disp=0, shadow=0, pending=0, digit=4'h0, an=4'b1110.
- Deasserting clr mid-scan restarts from digit 0 with a full PRESCALE hold. Any pending value is lost.
- First tick occurs PRESCALE cycles after clr deasserts. digit and an change on the same edge as the tick.
- pending rises on the edge that samples ld. It falls on the edge where disp updates.
- Load-to-display latency: a value loaded at frame position p appears on digit 0 at the next boundary edge. Worst case is 4*PRESCALE cycles; best case is 0 extra cycles (ld on the boundary edge).
- an never has more than one bit low. an and digit always change on the same edge.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: digit i (i>=1) is blanked (an=4'b1111 during its slot) when disp[15:4*i] is zero.
    - Digit 0 is never blanked, so x=0 shows a single "0".
    - digit still carries the nibble value during a blanked slot.
    - Blanking uses the disp value in effect for that slot.
  - Undefined: no blanking; all four digits are always lit in turn, and leading zeros are shown.

## Test plan
- Reset: assert clr for 3 cycles mid-scan -> digit=0, an=4'b1110, pending=0 immediately. After release, the first tick comes at PRESCALE cycles.
- Scan (PRESCALE=4): ld x=16'h1A2F on a boundary edge -> repeating digit/an sequence F/1110, 2/1101, A/1011, 1/0111, each held 4 cycles. pending stays 0.
- Buffered load: during the 16'h1A2F frame, ld 16'h3C4D at the digit-1 slot -> pending=1, and the rest of the frame still shows 2, A, 1. At the boundary edge, digit=D, an=1110, pending=0.
- Last write wins: ld 16'h1111 then 16'h2222 in the same frame -> next frame shows 2,2,2,2. 16'h1111 never appears.
- Blanking: x=16'h0005, and x=16'h0000:
  - With LEADING_ZERO_BLANK_EN, 16'h0005: an=1110 with digit 5, then an=1111 for 3*PRESCALE cycles.
  - Without the macro, 16'h0005: digits 0,0,0 are lit on 1101/1011/0111.
  - With the macro, 16'h0000: only digit 0 lit, showing 0.
- ld on boundary while pending: pending shadow=16'h1111, ld 16'h9999 exactly on the boundary edge -> next frame shows 9999. pending falls on that edge.
